// File: rtl/uart_pkg.sv
// Shared types and constants for the UART frame decoder.
// Checksum support is controlled by UART_FRAME_CHECKSUM_EN.
package uart_pkg;

  typedef logic [7:0] uart_byte_t;

  localparam uart_byte_t UART_SYNC_BYTE = 8'hA5;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_OPCODE,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHECK,
    ST_PRESENT
  } frame_state_e;

endpackage

// File: rtl/uart_commit_fifo.sv
// Payload FIFO with a speculative write pointer that is either
// committed or rolled back once the frame outcome is known.
module uart_commit_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en_i,
  input  uart_byte_t               wr_data_i,
  input  logic                     commit_i,
  input  logic                     rollback_i,
  input  logic                     rd_en_i,
  output logic [$clog2(DEPTH):0]   free_o,
  output logic                     empty_o,
  output uart_byte_t               head_o
);

  localparam int AW = $clog2(DEPTH);

  typedef logic [AW:0] ptr_t;

  uart_byte_t mem [DEPTH];

  ptr_t wsp_q, wsp_d;
  ptr_t wcm_q, wcm_d;
  ptr_t rd_q, rd_d;
  ptr_t occ;

  always_comb begin
    wsp_d = wsp_q;
    if (rollback_i) begin
      wsp_d = wcm_q;
    end else if (wr_en_i) begin
      wsp_d = wsp_q + ptr_t'(1);
    end
  end

  // A commit in the same cycle as the last write includes that byte.
  always_comb begin
    wcm_d = wcm_q;
    if (commit_i) begin
      wcm_d = wsp_q + ptr_t'(wr_en_i);
    end
  end

  assign rd_d = rd_q + ptr_t'(rd_en_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      wsp_q <= '0;
      wcm_q <= '0;
      rd_q  <= '0;
    end else begin
      wsp_q <= wsp_d;
      wcm_q <= wcm_d;
      rd_q  <= rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem[wsp_q[AW-1:0]] <= wr_data_i;
    end
  end

  assign occ     = wcm_q - rd_q;
  assign free_o  = ptr_t'(DEPTH) - occ;
  assign empty_o = (occ == '0);
  assign head_o  = mem[rd_q[AW-1:0]];

endmodule

// File: rtl/uart_frame_decoder.sv
// Frame parser: SYNC, OPCODE, LEN, payload and optional CHK byte.
// Define UART_FRAME_CHECKSUM_EN to require the trailing XOR byte.
module uart_frame_decoder
  import uart_pkg::*;
#(
  parameter int MAX_LEN    = 16,
  parameter int FIFO_DEPTH = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  uart_byte_t rx_byte,
  output logic       cmd_valid,
  input  logic       cmd_ready,
  output uart_byte_t cmd_opcode,
  output uart_byte_t cmd_len,
  output logic       pay_valid,
  input  logic       pay_ready,
  output uart_byte_t pay_data,
  output logic       err_len,
  output logic       err_ovf,
  output logic       err_chk
);

  localparam int FW = $clog2(FIFO_DEPTH) + 1;

`ifdef UART_FRAME_CHECKSUM_EN
  localparam frame_state_e ST_DONE = ST_CHECK;
`else
  localparam frame_state_e ST_DONE = ST_PRESENT;
`endif

  frame_state_e  state_q;
  uart_byte_t    op_q;
  uart_byte_t    len_q;
  uart_byte_t    cnt_q;
  logic          cmd_valid_q;
  logic          err_len_q;
  logic          err_ovf_q;
  logic          err_chk_q;
  logic [FW-1:0] free;
  logic          fifo_empty;
  uart_byte_t    head;
  logic          wr_en;
  logic          commit;
  logic          rollback;
  logic          rd_en;

`ifdef UART_FRAME_CHECKSUM_EN
  uart_byte_t    chk_q;

  assign commit   = rx_valid && (state_q == ST_CHECK)
                 && (rx_byte == chk_q);
  assign rollback = rx_valid && (state_q == ST_CHECK)
                 && (rx_byte != chk_q);
`else
  assign commit   = wr_en && (cnt_q == 8'd1);
  assign rollback = 1'b0;
`endif

  assign wr_en = rx_valid && (state_q == ST_PAYLOAD);
  assign rd_en = !fifo_empty && pay_ready;

  uart_commit_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (wr_en),
    .wr_data_i  (rx_byte),
    .commit_i   (commit),
    .rollback_i (rollback),
    .rd_en_i    (rd_en),
    .free_o     (free),
    .empty_o    (fifo_empty),
    .head_o     (head)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_HUNT;
      op_q        <= '0;
      len_q       <= '0;
      cnt_q       <= '0;
      cmd_valid_q <= 1'b0;
      err_len_q   <= 1'b0;
      err_ovf_q   <= 1'b0;
      err_chk_q   <= 1'b0;
`ifdef UART_FRAME_CHECKSUM_EN
      chk_q       <= '0;
`endif
    end else begin
      err_len_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_chk_q <= 1'b0;
      unique case (state_q)
        ST_HUNT: begin
          if (rx_valid && rx_byte == UART_SYNC_BYTE) begin
            state_q <= ST_OPCODE;
          end
        end
        ST_OPCODE: begin
          if (rx_valid) begin
            op_q    <= rx_byte;
            state_q <= ST_LEN;
`ifdef UART_FRAME_CHECKSUM_EN
            chk_q   <= rx_byte;
`endif
          end
        end
        ST_LEN: begin
          if (rx_valid) begin
            if (int'(rx_byte) > MAX_LEN) begin
              err_len_q <= 1'b1;
              state_q   <= ST_HUNT;
            end else if (int'(rx_byte) > int'(free)) begin
              err_ovf_q <= 1'b1;
              state_q   <= ST_HUNT;
            end else begin
              len_q <= rx_byte;
              cnt_q <= rx_byte;
`ifdef UART_FRAME_CHECKSUM_EN
              chk_q <= chk_q ^ rx_byte;
`endif
              if (rx_byte == 8'd0) begin
                state_q     <= ST_DONE;
                cmd_valid_q <= (ST_DONE == ST_PRESENT);
              end else begin
                state_q <= ST_PAYLOAD;
              end
            end
          end
        end
        ST_PAYLOAD: begin
          if (rx_valid) begin
            cnt_q <= cnt_q - 8'd1;
`ifdef UART_FRAME_CHECKSUM_EN
            chk_q <= chk_q ^ rx_byte;
`endif
            if (cnt_q == 8'd1) begin
              state_q     <= ST_DONE;
              cmd_valid_q <= (ST_DONE == ST_PRESENT);
            end
          end
        end
`ifdef UART_FRAME_CHECKSUM_EN
        ST_CHECK: begin
          if (rx_valid) begin
            if (rx_byte == chk_q) begin
              state_q     <= ST_PRESENT;
              cmd_valid_q <= 1'b1;
            end else begin
              err_chk_q <= 1'b1;
              state_q   <= ST_HUNT;
            end
          end
        end
`endif
        ST_PRESENT: begin
          // The consumer owns the header; anything arriving now is lost.
          if (rx_valid) begin
            err_ovf_q <= 1'b1;
          end
          if (cmd_ready) begin
            cmd_valid_q <= 1'b0;
            state_q     <= ST_HUNT;
          end
        end
        default: begin
          state_q <= ST_HUNT;
        end
      endcase
    end
  end

  assign cmd_valid  = cmd_valid_q;
  assign cmd_opcode = op_q;
  assign cmd_len    = len_q;
  assign pay_valid  = !fifo_empty;
  assign pay_data   = head;
  assign err_len    = err_len_q;
  assign err_ovf    = err_ovf_q;
  assign err_chk    = err_chk_q;

endmodule

// File: doc/uart_frame_decoder.md
# uart_frame_decoder

Byte-level frame parser directly downstream of the 8-bit UART receiver. Consumes the receiver's one-cycle byte strobes, locks onto a sync byte, and extracts opcode, length and payload. Payload bytes are held in a commit-on-success FIFO, and a completed command is presented to the TPU control logic over a ready/valid handshake. Bad or oversized frames are discarded without side effects.

## Interface
- MAX_LEN, 16: maximum payload bytes per frame (1..255)
- FIFO_DEPTH, 32: payload FIFO entries; power of two, ≥ MAX_LEN
- clk  input  1  single clock for the whole block
- rst  input  1  reset; synchronous, active-high
- rx_valid  input  1  one-cycle strobe, rx_byte valid
- rx_byte  input  8  received byte
- cmd_valid  output  1  command header available
- cmd_ready  input  1  consumer accepts header
- cmd_opcode  output  8  opcode of presented frame
- cmd_len  output  8  payload length of presented frame
- pay_valid  output  1  committed payload byte available
- pay_ready  input  1  consumer pops payload byte
- pay_data  output  8  FIFO head byte
- err_len  output  1  one-cycle pulse: LEN > MAX_LEN
- err_ovf  output  1  one-cycle pulse: frame dropped (no FIFO space, or byte arrived while PRESENT)
- err_chk  output  1  one-cycle pulse: checksum mismatch

## Operation
- Frame: SYNC (0xA5), OPCODE, LEN, LEN payload bytes, CHK (when checksum is compiled in). CHK is the XOR of OPCODE, LEN and all payload bytes.
- States: HUNT → OPCODE → LEN → PAYLOAD → CHECK → PRESENT → HUNT.
- HUNT: bytes other than 0xA5 are ignored.
- LEN byte handling:
  - LEN > MAX_LEN: pulse err_len, go to HUNT.
  - LEN > free FIFO space (FIFO_DEPTH − committed occupancy): pulse err_ovf, go to HUNT.
  - LEN == 0: skip PAYLOAD.
- PAYLOAD: each byte is written at the speculative write pointer. A down-counter loaded with LEN ends the state.
- CHECK:
  - Match: commit (committed wr_ptr ← speculative wr_ptr), go to PRESENT.
  - Mismatch: pulse err_chk, roll back (speculative ← committed), go to HUNT.
- PRESENT:
  - cmd_valid = 1; cmd_opcode and cmd_len are held stable.
  - cmd_valid && cmd_ready → HUNT.
  - Any rx_valid while in PRESENT: byte dropped, err_ovf pulsed, state unchanged.
- Payload read side is independent of the parser. pay_valid = (committed occupancy ≠ 0). A pop happens on pay_valid && pay_ready. Uncommitted bytes are never visible.
- Pointers are log2(FIFO_DEPTH)+1 bits wide; full and empty are distinguished by the MSB; wrap-around is natural.
- Simultaneous pop and write in the same cycle are both honoured. Free space is computed from the pre-pop read pointer, which is conservative.
- Reset mid-frame: state HUNT, all pointers 0, FIFO contents discarded.
- Reset values: cmd_valid, pay_valid, err_* = 0; cmd_opcode, cmd_len = 0. pay_data is don't-care while pay_valid = 0.

## Timing
- All outputs are registered.
- err_* pulses are high exactly one cycle, in the cycle after the offending rx_valid.
- cmd_valid and pay_valid for a frame rise in the cycle after the rx_valid carrying CHK. Without checksum, they rise after the last payload byte, or after the LEN byte when LEN == 0.
- Handshake: cmd_valid stays high until accepted. The header is consumed on the cycle cmd_valid && cmd_ready. The parser reaches HUNT the next cycle, and the next SYNC is accepted on that cycle.
- pay_data updates the cycle after a pop. A byte committed this cycle is poppable next cycle.

## Configuration
- UART_FRAME_CHECKSUM_EN defined:
  - CHECK state exists.
  - Running XOR register present.
  - err_chk active.
- Undefined:
  - No CHK byte on the wire.
  - Commit occurs on the last payload byte (or on LEN when LEN == 0).
  - CHECK state and XOR register are absent.
  - err_chk is tied 0.

## Structure
- Shared package uart_pkg:
  - UART_SYNC_BYTE = 8'hA5
  - frame_state_e enum
  - uart_byte_t typedef
- Sub-module uart_commit_fifo:
  - Dual-pointer FIFO: speculative wr_ptr, committed wr_ptr, rd_ptr.
  - Inputs: wr_en, commit, rollback, rd_en.
  - Outputs: free count, empty, head data.
- Parser FSM, length counter and XOR live in uart_frame_decoder.

## Test plan
- Good frame: A5 10 02 33 44 65 (CHK_EN) → one cycle after 65, cmd_valid = 1, opcode 0x10, len 2; pops yield 0x33 then 0x44; FIFO empty.
- Bad checksum: A5 10 02 33 44 66 → err_chk pulse, no cmd_valid, pay_valid stays 0; following good frame is decoded normally.
- Oversized: A5 20 11 with MAX_LEN=16 → err_len pulse; remaining bytes ignored until the next A5.
- Back-pressure: hold cmd_ready = 0, send a byte during PRESENT → err_ovf pulse; opcode and len unchanged; raise cmd_ready → HUNT.
- Fill and wrap: FIFO_DEPTH=32, two 16-byte frames with no pops, then a third frame → err_ovf at its LEN byte; pop all 32 bytes in order, then send a frame that crosses the pointer wrap → correct data.
- Reset mid-PAYLOAD → cmd_valid = 0, pay_valid = 0 the next cycle; a fresh frame after reset is decoded correctly.
